// File: rtl/cmp_pkg.sv
// -----------------------------------------------------------------------------
// cmp_pkg
// Shared types and helpers for the comparator result filter.
//   rel_e          : 2-bit relation encoding (NONE/EQ/LT/GT)
//   state_e        : qualification FSM states (IDLE/TRACK/LOCKED)
//   dec_t          : decoded sample (relation plus malformed flag)
//   onehot3_decode : maps the three comparator flags to a dec_t
// -----------------------------------------------------------------------------
package cmp_pkg;

    localparam int REL_W = 2;

    typedef enum logic [REL_W-1:0] {
        REL_NONE = 2'b00,
        REL_EQ   = 2'b01,
        REL_LT   = 2'b10,
        REL_GT   = 2'b11
    } rel_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRACK  = 2'b01,
        LOCKED = 2'b10
    } state_e;

    typedef struct packed {
        rel_e rel;
        logic bad;
    } dec_t;

    // Exactly one flag high gives a relation; anything else is malformed.
    function automatic dec_t onehot3_decode(input logic eq, input logic lt, input logic gt);
        dec_t r;
        r.rel = REL_NONE;
        r.bad = 1'b1;
        case ({eq, lt, gt})
            3'b100: begin
                r.rel = REL_EQ;
                r.bad = 1'b0;
            end
            3'b010: begin
                r.rel = REL_LT;
                r.bad = 1'b0;
            end
            3'b001: begin
                r.rel = REL_GT;
                r.bad = 1'b0;
            end
            default: begin
                r.rel = REL_NONE;
                r.bad = 1'b1;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp_result_filter_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear and load.
// Priority: clr_i > ld_i > inc_i. Increment stops at max_i (never wraps).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (count -> 0)
//   clr_i        : synchronous clear to zero
//   ld_i/ld_val_i: synchronous load of ld_val_i
//   inc_i        : increment request
//   max_i        : saturation limit
//   cnt_o        : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] ld_val_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] max_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear, load, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (inc_i && (cnt_q < max_i)) begin
            cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cmp_result_filter.sv
// -----------------------------------------------------------------------------
// cmp_result_filter
// Debounces the comparator's one-hot EQ/LT/GT flags: a relation is reported
// on stable_rel only after STABLE_CNT consecutive valid matching samples
// (gaps with in_valid=0 do not break a run). Malformed samples set a sticky
// fmt_err and restart qualification from IDLE.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid            : qualifies eq_in/lt_in/gt_in
//   eq_in, lt_in, gt_in : comparator flags
//   stable_rel          : accepted relation (00 none, 01 EQ, 10 LT, 11 GT)
//   rel_valid           : stable_rel holds an accepted relation
//   rel_change          : one-cycle pulse when stable_rel takes a new value
//   fmt_err             : sticky malformed-sample flag
//   err_clr             : synchronous clear of fmt_err (a same-cycle BAD wins)
// Optional (macro CMP_FILT_STATS_EN):
//   stats_clr           : synchronous clear of the statistics counters
//   eq_cnt/lt_cnt/gt_cnt/bad_cnt : saturating per-class sample counts
// -----------------------------------------------------------------------------
module cmp_result_filter
    import cmp_pkg::*;
#(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             eq_in,
    input  logic             lt_in,
    input  logic             gt_in,
    output logic [1:0]       stable_rel,
    output logic             rel_valid,
    output logic             rel_change,
    output logic             fmt_err,
    input  logic             err_clr
`ifdef CMP_FILT_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] bad_cnt
`endif
);

    localparam logic [CNT_W-1:0] RUN_MAX_C  = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W:0]   RUN_GOAL_C = (CNT_W+1)'(STABLE_CNT);
    localparam logic [CNT_W-1:0] RUN_ONE_C  = CNT_W'(1);
    localparam bit               ONE_SHOT_C = (STABLE_CNT == 1);

    state_e           state_q, state_d;
    rel_e             cand_q, cand_d;
    rel_e             stable_q, stable_d;
    logic             rel_valid_q, rel_valid_d;
    logic             rel_change_q, rel_change_d;
    logic             fmt_err_q, fmt_err_d;

    dec_t             dec_s;
    logic [CNT_W-1:0] run_s;
    logic             run_clr_s;
    logic             run_ld_s;
    logic             run_inc_s;
    logic             restart_s;
    logic             accept_s;
    rel_e             accept_rel_s;

    assign dec_s = onehot3_decode(eq_in, lt_in, gt_in);

    // Run length of the current candidate; saturates at STABLE_CNT.
    sat_counter #(.WIDTH(CNT_W)) u_run_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (run_clr_s),
        .ld_i     (run_ld_s),
        .ld_val_i (RUN_ONE_C),
        .inc_i    (run_inc_s),
        .max_i    (RUN_MAX_C),
        .cnt_o    (run_s)
    );

    // Qualification FSM: next state, candidate, accepted relation and flags.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        stable_d     = stable_q;
        rel_valid_d  = rel_valid_q;
        rel_change_d = 1'b0;
        fmt_err_d    = fmt_err_q;
        run_clr_s    = 1'b0;
        run_ld_s     = 1'b0;
        run_inc_s    = 1'b0;
        restart_s    = 1'b0;
        accept_s     = 1'b0;
        accept_rel_s = cand_q;

        if (err_clr) begin
            fmt_err_d = 1'b0;
        end else begin
            fmt_err_d = fmt_err_q;
        end

        if (in_valid) begin
            if (dec_s.bad) begin
                // Set beats err_clr; accepted relation is left untouched.
                fmt_err_d = 1'b1;
                run_clr_s = 1'b1;
                state_d   = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        restart_s = 1'b1;
                    end
                    TRACK: begin
                        if (dec_s.rel == cand_q) begin
                            run_inc_s = 1'b1;
                            // This sample completes the run when run+1 reaches the goal.
                            if (({1'b0, run_s} + {{CNT_W{1'b0}}, 1'b1}) >= RUN_GOAL_C) begin
                                accept_s     = 1'b1;
                                accept_rel_s = cand_q;
                            end else begin
                                accept_s = 1'b0;
                            end
                        end else begin
                            restart_s = 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (dec_s.rel == stable_q) begin
                            restart_s = 1'b0;
                        end else begin
                            restart_s = 1'b1;
                        end
                    end
                    default: begin
                        run_clr_s = 1'b1;
                        state_d   = IDLE;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end

        // A new candidate starts a run of one; with STABLE_CNT==1 that is already enough.
        if (restart_s) begin
            cand_d   = dec_s.rel;
            run_ld_s = 1'b1;
            if (ONE_SHOT_C) begin
                accept_s     = 1'b1;
                accept_rel_s = dec_s.rel;
            end else begin
                state_d = TRACK;
            end
        end else begin
            cand_d = cand_d;
        end

        if (accept_s) begin
            stable_d     = accept_rel_s;
            rel_valid_d  = 1'b1;
            rel_change_d = (accept_rel_s != stable_q);
            state_d      = LOCKED;
        end else begin
            stable_d = stable_d;
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cand_q       <= REL_NONE;
            stable_q     <= REL_NONE;
            rel_valid_q  <= 1'b0;
            rel_change_q <= 1'b0;
            fmt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            stable_q     <= stable_d;
            rel_valid_q  <= rel_valid_d;
            rel_change_q <= rel_change_d;
            fmt_err_q    <= fmt_err_d;
        end
    end

    assign stable_rel = stable_q;
    assign rel_valid  = rel_valid_q;
    assign rel_change = rel_change_q;
    assign fmt_err    = fmt_err_q;

`ifdef CMP_FILT_STATS_EN
    localparam logic [CNT_W-1:0] STAT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};

    logic eq_inc_s;
    logic lt_inc_s;
    logic gt_inc_s;
    logic bad_inc_s;

    assign eq_inc_s  = in_valid & ~dec_s.bad & (dec_s.rel == REL_EQ);
    assign lt_inc_s  = in_valid & ~dec_s.bad & (dec_s.rel == REL_LT);
    assign gt_inc_s  = in_valid & ~dec_s.bad & (dec_s.rel == REL_GT);
    assign bad_inc_s = in_valid &  dec_s.bad;

    sat_counter #(.WIDTH(CNT_W)) u_eq_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(stats_clr), .ld_i(1'b0), .ld_val_i(ZERO_C),
        .inc_i(eq_inc_s), .max_i(STAT_MAX_C), .cnt_o(eq_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_lt_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(stats_clr), .ld_i(1'b0), .ld_val_i(ZERO_C),
        .inc_i(lt_inc_s), .max_i(STAT_MAX_C), .cnt_o(lt_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_gt_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(stats_clr), .ld_i(1'b0), .ld_val_i(ZERO_C),
        .inc_i(gt_inc_s), .max_i(STAT_MAX_C), .cnt_o(gt_cnt)
    );
    sat_counter #(.WIDTH(CNT_W)) u_bad_cnt (
        .clk(clk), .rst_n(rst_n), .clr_i(stats_clr), .ld_i(1'b0), .ld_val_i(ZERO_C),
        .inc_i(bad_inc_s), .max_i(STAT_MAX_C), .cnt_o(bad_cnt)
    );
`endif

endmodule

// File: tb/tb_cmp_result_filter.sv
// -----------------------------------------------------------------------------
// tb_cmp_result_filter
// Directed bench for cmp_result_filter (STABLE_CNT=4, CNT_W=8). Inputs change
// 1 time unit after a rising edge; outputs are checked 1 time unit after the
// edge that registers each sample. Statistics checks are built only when
// CMP_FILT_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_cmp_result_filter;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             eq_in;
    logic             lt_in;
    logic             gt_in;
    logic [1:0]       stable_rel;
    logic             rel_valid;
    logic             rel_change;
    logic             fmt_err;
    logic             err_clr;
`ifdef CMP_FILT_STATS_EN
    logic             stats_clr;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] bad_cnt;
`endif

    int checks;
    int failures;

    cmp_result_filter #(.STABLE_CNT(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .eq_in      (eq_in),
        .lt_in      (lt_in),
        .gt_in      (gt_in),
        .stable_rel (stable_rel),
        .rel_valid  (rel_valid),
        .rel_change (rel_change),
        .fmt_err    (fmt_err),
        .err_clr    (err_clr)
`ifdef CMP_FILT_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .eq_cnt     (eq_cnt),
        .lt_cnt     (lt_cnt),
        .gt_cnt     (gt_cnt),
        .bad_cnt    (bad_cnt)
`endif
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Apply one sample ({eq,lt,gt}) for one clock, then settle just past the edge.
    task automatic step(input logic v, input logic [2:0] f);
        in_valid = v;
        eq_in    = f[2];
        lt_in    = f[1];
        gt_in    = f[0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] rel, input logic vld,
                             input logic chg, input logic err);
        check({tag, ".rel"}, {30'd0, stable_rel}, {30'd0, rel});
        check({tag, ".vld"}, {31'd0, rel_valid},  {31'd0, vld});
        check({tag, ".chg"}, {31'd0, rel_change}, {31'd0, chg});
        check({tag, ".err"}, {31'd0, fmt_err},    {31'd0, err});
    endtask

    localparam logic [2:0] F_EQ   = 3'b100;
    localparam logic [2:0] F_LT   = 3'b010;
    localparam logic [2:0] F_GT   = 3'b001;
    localparam logic [2:0] F_EQGT = 3'b101;
    localparam logic [2:0] F_NONE = 3'b000;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        eq_in    = 1'b0;
        lt_in    = 1'b0;
        gt_in    = 1'b0;
        err_clr  = 1'b0;
`ifdef CMP_FILT_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_out("reset", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Four EQ samples: accepted after the fourth.
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, F_EQ);
            check_out("eq_run", 2'b00, 1'b0, 1'b0, 1'b0);
        end
        step(1'b1, F_EQ);
        check_out("eq_acc", 2'b01, 1'b1, 1'b1, 1'b0);
        step(1'b0, F_NONE);
        check_out("eq_pulse_end", 2'b01, 1'b1, 1'b0, 1'b0);

        // 3 LT, 1 GT breaks the run, then 4 LT switch to LT.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, F_LT);
            check_out("lt_broken", 2'b01, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, F_GT);
        check_out("gt_break", 2'b01, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, F_LT);
            check_out("lt_run", 2'b01, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, F_LT);
        check_out("lt_acc", 2'b10, 1'b1, 1'b1, 1'b0);

        // GT run with a five-cycle gap in the middle.
        step(1'b1, F_GT);
        step(1'b1, F_GT);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, F_GT);
            check_out("gap", 2'b10, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, F_GT);
        check_out("gt_3rd", 2'b10, 1'b1, 1'b0, 1'b0);
        step(1'b1, F_GT);
        check_out("gt_acc", 2'b11, 1'b1, 1'b1, 1'b0);

        // Malformed sample: sticky error, relation untouched.
        step(1'b1, F_EQGT);
        check_out("bad", 2'b11, 1'b1, 1'b0, 1'b1);
        // 3 LT, an all-zero BAD, 1 LT: the BAD restarts the run so no acceptance.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, F_LT);
        end
        step(1'b1, F_NONE);
        check_out("bad_zero", 2'b11, 1'b1, 1'b0, 1'b1);
        step(1'b1, F_LT);
        check_out("bad_restart", 2'b11, 1'b1, 1'b0, 1'b1);
        // err_clr together with a BAD sample: set wins.
        err_clr = 1'b1;
        step(1'b1, F_EQGT);
        check_out("clr_vs_bad", 2'b11, 1'b1, 1'b0, 1'b1);
        step(1'b0, F_NONE);
        err_clr = 1'b0;
        check_out("clr_alone", 2'b11, 1'b1, 1'b0, 1'b0);
        // Malformed flags without in_valid are ignored.
        step(1'b0, F_EQGT);
        check_out("bad_invalid", 2'b11, 1'b1, 1'b0, 1'b0);

        // Reset mid-run (run=3) then a single EQ must not accept.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, F_EQ);
        end
        check_out("pre_rst", 2'b11, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 2'b00, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, F_EQ);
        check_out("post_rst1", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, F_EQ);
        step(1'b1, F_EQ);
        check_out("post_rst3", 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b1, F_EQ);
        check_out("post_rst_acc", 2'b01, 1'b1, 1'b1, 1'b0);

        // Re-qualifying the same relation gives no change pulse.
        step(1'b1, F_LT);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, F_EQ);
        end
        check_out("same_rel", 2'b01, 1'b1, 1'b0, 1'b0);

`ifdef CMP_FILT_STATS_EN
        stats_clr = 1'b1;
        step(1'b0, F_NONE);
        stats_clr = 1'b0;
        check("st_clr_eq", {24'd0, eq_cnt}, 32'd0);
        check("st_clr_lt", {24'd0, lt_cnt}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, F_LT);
        end
        check("st_lt_sat", {24'd0, lt_cnt}, 32'd255);
        check("st_eq_zero", {24'd0, eq_cnt}, 32'd0);
        // Clear wins over a same-cycle count.
        stats_clr = 1'b1;
        step(1'b1, F_LT);
        stats_clr = 1'b0;
        check("st_clr_lt2", {24'd0, lt_cnt}, 32'd0);
        check("st_clr_gt", {24'd0, gt_cnt}, 32'd0);
        check("st_clr_bad", {24'd0, bad_cnt}, 32'd0);
        step(1'b1, F_EQ);
        step(1'b1, F_EQ);
        step(1'b1, F_EQGT);
        step(1'b1, F_GT);
        check("st_eq2", {24'd0, eq_cnt}, 32'd2);
        check("st_bad1", {24'd0, bad_cnt}, 32'd1);
        check("st_gt1", {24'd0, gt_cnt}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
